// File: rtl/s10077_sensor_model_if.sv
// Sensor-side bundle: SENSOR_CLK/ST toward the sensor model, readout response back.
interface s10077_sensor_model_if #(
  parameter int unsigned DW = 10,
  parameter int unsigned IW = 10
);
  logic          SENSOR_CLK;
  logic          ST;
  logic          TRIG;
  logic [DW-1:0] PIX_DATA;
  logic [IW-1:0] PIX_IDX;
  logic          EOS;
  logic          EOC;
  logic          BUSY;
  logic [23:0]   INTEG_LEN;
  logic          ERR_SHORT;
  logic          ERR_OVR;

  // FPGA side: drives the sensor clock and start, observes the response
  modport master (
    output SENSOR_CLK, ST,
    input  TRIG, PIX_DATA, PIX_IDX, EOS, EOC, BUSY, INTEG_LEN, ERR_SHORT, ERR_OVR
  );

  // Sensor model side
  modport slave (
    input  SENSOR_CLK, ST,
    output TRIG, PIX_DATA, PIX_IDX, EOS, EOC, BUSY, INTEG_LEN, ERR_SHORT, ERR_OVR
  );
endinterface

// File: rtl/s10077_sensor_model.sv
// Line-sensor readout model: measures ST integration, then answers with per-pixel
// TRIG/PIX_DATA, EOS on the last pixel and an EOC level. Advances only on synced
// SENSOR_CLK rising edges (tick).
module s10077_sensor_model #(
  parameter int unsigned NPIX      = 1024,
  parameter int unsigned LEAD_CLKS = 48,
  parameter int unsigned MIN_INTEG = 4,
  parameter int unsigned EOC_CLKS  = 1,
  parameter int unsigned DW        = 10,
  parameter int unsigned SEED      = 0
) (
  input logic                  FPGA_CLK,
  input logic                  FPGA_RST,
  s10077_sensor_model_if.slave sensor_io
);

  localparam int unsigned IW = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StInteg = 3'd1;
  localparam logic [2:0] StLead  = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StEoc   = 3'd4;

  localparam logic [23:0]   MinInteg = 24'(MIN_INTEG);
  localparam logic [23:0]   LeadClks = 24'(LEAD_CLKS);
  localparam logic [23:0]   EocClks  = 24'(EOC_CLKS);
  localparam logic [IW-1:0] LastIdx  = IW'(NPIX - 1);

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic st_meta_q, st_s_q;
  logic tick_d, tick_q;

  logic [2:0]    state_d, state_q;
  logic [23:0]   cnt_d, cnt_q;
  logic          st_prev_d, st_prev_q;
  logic          trig_d, trig_q;
  logic [DW-1:0] data_d, data_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          eos_d, eos_q;
  logic          eoc_d, eoc_q;
  logic          busy_d, busy_q;
  logic [23:0]   integ_d, integ_q;
  logic          err_short_d, err_short_q;
  logic          err_ovr_d, err_ovr_q;

  logic          st_rise;
  logic          emit;
  logic [IW-1:0] emit_idx;
  logic [31:0]   pix_sum;

  // Synchronizers; ST side resets high so a held-high ST never looks like a fresh rise
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      st_meta_q   <= 1'b1;
      st_s_q      <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      sclk_meta_q <= sensor_io.SENSOR_CLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      st_meta_q   <= sensor_io.ST;
      st_s_q      <= st_meta_q;
      tick_q      <= tick_d;
    end
  end

  // Protocol state and output next-state, evaluated only on tick
  always_comb begin
    tick_d      = sclk_sync_q & ~sclk_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_prev_d   = st_prev_q;
    trig_d      = 1'b0;
    data_d      = data_q;
    idx_d       = idx_q;
    eos_d       = eos_q;
    eoc_d       = eoc_q;
    integ_d     = integ_q;
    err_short_d = 1'b0;
    err_ovr_d   = 1'b0;
    st_rise     = 1'b0;
    emit        = 1'b0;
    emit_idx    = '0;
    pix_sum     = '0;

    if (tick_q) begin
      st_prev_d = st_s_q;
      st_rise   = st_s_q & ~st_prev_q;

      unique case (state_q)
        StIdle: begin
          if (st_rise) begin
            state_d = StInteg;
            cnt_d   = 24'd1;
          end
        end
        StInteg: begin
          if (st_s_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + 24'd1;
          end else if (cnt_q < MinInteg) begin
            state_d     = StIdle;
            err_short_d = 1'b1;
          end else begin
            integ_d = cnt_q;
            state_d = StLead;
            cnt_d   = '0;
          end
        end
        StLead: begin
          cnt_d = cnt_q + 24'd1;
          if (cnt_d == LeadClks) begin
            state_d = StRead;
            emit    = 1'b1;
          end
        end
        StRead: begin
          if (idx_q == LastIdx) begin
            state_d = StEoc;
            eos_d   = 1'b0;
            eoc_d   = 1'b1;
            cnt_d   = 24'd1;
          end else begin
            emit     = 1'b1;
            emit_idx = idx_q + IW'(1);
          end
        end
        StEoc: begin
          if (cnt_q == EocClks) begin
            eoc_d   = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      // A rise can only be seen outside INTEG, since INTEG is left as soon as ST drops
      if (st_rise && (state_q inside {StLead, StRead, StEoc})) err_ovr_d = 1'b1;

      if (emit) begin
        pix_sum = SEED + 32'(emit_idx);
        trig_d  = 1'b1;
        idx_d   = emit_idx;
        data_d  = pix_sum[DW-1:0];
        eos_d   = (emit_idx == LastIdx);
      end
    end

    busy_d = (state_d != StIdle);
  end

  // Protocol registers; reset forces IDLE and clears every output at once
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      st_prev_q   <= 1'b1;
      trig_q      <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      eos_q       <= 1'b0;
      eoc_q       <= 1'b0;
      busy_q      <= 1'b0;
      integ_q     <= '0;
      err_short_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_prev_q   <= st_prev_d;
      trig_q      <= trig_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      eos_q       <= eos_d;
      eoc_q       <= eoc_d;
      busy_q      <= busy_d;
      integ_q     <= integ_d;
      err_short_q <= err_short_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign sensor_io.TRIG      = trig_q;
  assign sensor_io.PIX_DATA  = data_q;
  assign sensor_io.PIX_IDX   = idx_q;
  assign sensor_io.EOS       = eos_q;
  assign sensor_io.EOC       = eoc_q;
  assign sensor_io.BUSY      = busy_q;
  assign sensor_io.INTEG_LEN = integ_q;
  assign sensor_io.ERR_SHORT = err_short_q;
  assign sensor_io.ERR_OVR   = err_ovr_q;

endmodule

// File: tb/tb_s10077_sensor_model.sv
// Directed bench for the sensor model: SENSOR_CLK = FPGA_CLK/16, NPIX=8, LEAD=3, EOC=2.
module tb_s10077_sensor_model;

  logic FPGA_CLK;
  logic FPGA_RST;

  s10077_sensor_model_if #(.DW(10), .IW(3)) sif ();

  s10077_sensor_model #(
    .NPIX     (8),
    .LEAD_CLKS(3),
    .MIN_INTEG(4),
    .EOC_CLKS (2),
    .DW       (10),
    .SEED     (32'h3FC)
  ) dut (
    .FPGA_CLK (FPGA_CLK),
    .FPGA_RST (FPGA_RST),
    .sensor_io(sif)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  int n_total = 0;
  int n_bad   = 0;

  int sc_n = 0;
  logic eoc_at  [0:1023];
  logic busy_at [0:1023];
  logic eos_at  [0:1023];

  int       trig_tick [$];
  int       trig_data [$];
  int       trig_idx  [$];
  int       trig_eos  [$];
  int       err_short_n = 0;
  int       err_ovr_n   = 0;
  int       busy_cyc_n  = 0;
  int       eoc_rise_n  = 0;
  logic     eoc_prev    = 1'b0;

  logic [9:0] exp_data [0:7] = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF,
                                 10'h000, 10'h001, 10'h002, 10'h003};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling FPGA_CLK edge
  always @(negedge FPGA_CLK) begin
    if (sif.TRIG === 1'b1) begin
      trig_tick.push_back(sc_n);
      trig_data.push_back(int'(sif.PIX_DATA));
      trig_idx.push_back(int'(sif.PIX_IDX));
      trig_eos.push_back(int'(sif.EOS));
    end
    if (sif.ERR_SHORT === 1'b1) err_short_n++;
    if (sif.ERR_OVR === 1'b1) err_ovr_n++;
    if (sif.BUSY === 1'b1) busy_cyc_n++;
    if (sif.EOC === 1'b1 && eoc_prev === 1'b0) eoc_rise_n++;
    eoc_prev = sif.EOC;
  end

  // One sensor period; ST is set mid-low so the rise samples st_val
  task automatic sclk(input logic st_val);
    sif.ST = st_val;
    repeat (4) @(negedge FPGA_CLK);
    sif.SENSOR_CLK = 1'b1;
    sc_n++;
    repeat (8) @(negedge FPGA_CLK);
    eoc_at[sc_n]  = sif.EOC;
    busy_at[sc_n] = sif.BUSY;
    eos_at[sc_n]  = sif.EOS;
    sif.SENSOR_CLK = 1'b0;
    repeat (4) @(negedge FPGA_CLK);
  endtask

  task automatic run_cycle(input int hi_len, output int t0, output int tbase);
    tbase = trig_tick.size();
    sclk(1'b0);
    repeat (hi_len) sclk(1'b1);
    sclk(1'b0);
    t0 = sc_n;
    repeat (15) sclk(1'b0);
  endtask

  task automatic check_cycle(input string pfx, input int t0, input int tbase,
                             input int exp_len);
    check_eq({pfx, ".integ_len"}, sif.INTEG_LEN, exp_len);
    check_eq({pfx, ".trig_count"}, trig_tick.size() - tbase, 8);
    for (int i = 0; i < 8; i++) begin
      if (tbase + i < trig_tick.size()) begin
        check_eq($sformatf("%s.tick%0d", pfx, i), trig_tick[tbase+i] - t0, 3 + i);
        check_eq($sformatf("%s.data%0d", pfx, i), trig_data[tbase+i], exp_data[i]);
        check_eq($sformatf("%s.idx%0d", pfx, i), trig_idx[tbase+i], i);
        check_eq($sformatf("%s.eos%0d", pfx, i), trig_eos[tbase+i], (i == 7) ? 1 : 0);
      end
    end
    check_eq({pfx, ".eos_t10"}, eos_at[t0+10], 1);
    check_eq({pfx, ".eos_t11"}, eos_at[t0+11], 0);
    check_eq({pfx, ".eoc_t10"}, eoc_at[t0+10], 0);
    check_eq({pfx, ".eoc_t11"}, eoc_at[t0+11], 1);
    check_eq({pfx, ".eoc_t12"}, eoc_at[t0+12], 1);
    check_eq({pfx, ".eoc_t13"}, eoc_at[t0+13], 0);
    check_eq({pfx, ".busy_t12"}, busy_at[t0+12], 1);
    check_eq({pfx, ".busy_t13"}, busy_at[t0+13], 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, ".trig"}, sif.TRIG, 0);
    check_eq({pfx, ".pix_data"}, sif.PIX_DATA, 0);
    check_eq({pfx, ".pix_idx"}, sif.PIX_IDX, 0);
    check_eq({pfx, ".eos"}, sif.EOS, 0);
    check_eq({pfx, ".eoc"}, sif.EOC, 0);
    check_eq({pfx, ".busy"}, sif.BUSY, 0);
    check_eq({pfx, ".integ_len"}, sif.INTEG_LEN, 0);
    check_eq({pfx, ".err_short"}, sif.ERR_SHORT, 0);
    check_eq({pfx, ".err_ovr"}, sif.ERR_OVR, 0);
  endtask

  initial begin
    int t0, tbase, b_short, b_ovr, b_busy, b_eoc;

    // 1: reset with ST held high, then free-running sensor clock
    FPGA_RST = 1'b0;
    sif.ST = 1'b1;
    sif.SENSOR_CLK = 1'b0;
    repeat (3) @(negedge FPGA_CLK);
    FPGA_RST = 1'b1;
    tbase  = trig_tick.size();
    b_busy = busy_cyc_n;
    repeat (10) sclk(1'b1);
    check_eq("s1.busy_cycles", busy_cyc_n - b_busy, 0);
    check_eq("s1.trig_count", trig_tick.size() - tbase, 0);
    check_all_zero("s1");

    // 2: normal cycle, ST high for 6 sensor clocks
    b_short = err_short_n;
    b_ovr   = err_ovr_n;
    run_cycle(6, t0, tbase);
    check_cycle("s2", t0, tbase, 6);
    check_eq("s2.err_short", err_short_n - b_short, 0);
    check_eq("s2.err_ovr", err_ovr_n - b_ovr, 0);

    // 3: short integration is rejected
    tbase   = trig_tick.size();
    b_short = err_short_n;
    sclk(1'b0);
    repeat (3) sclk(1'b1);
    check_eq("s3.busy_integ", sif.BUSY, 1);
    sclk(1'b0);
    repeat (6) sclk(1'b0);
    check_eq("s3.err_short", err_short_n - b_short, 1);
    check_eq("s3.trig_count", trig_tick.size() - tbase, 0);
    check_eq("s3.integ_len", sif.INTEG_LEN, 6);
    check_eq("s3.busy", sif.BUSY, 0);

    // 4: ST re-raised at pixel 2 (tick 5), held through EOC
    b_ovr = err_ovr_n;
    tbase = trig_tick.size();
    sclk(1'b0);
    repeat (6) sclk(1'b1);
    sclk(1'b0);
    t0 = sc_n;
    repeat (4) sclk(1'b0);
    repeat (10) sclk(1'b1);
    sclk(1'b0);
    check_cycle("s4", t0, tbase, 6);
    check_eq("s4.err_ovr", err_ovr_n - b_ovr, 1);
    run_cycle(5, t0, tbase);
    check_cycle("s4b", t0, tbase, 5);
    check_eq("s4b.err_ovr", err_ovr_n - b_ovr, 1);

    // 5: reset at pixel 5 (tick 8)
    b_eoc = eoc_rise_n;
    sclk(1'b0);
    repeat (6) sclk(1'b1);
    sclk(1'b0);
    repeat (8) sclk(1'b0);
    check_eq("s5.pre_idx", sif.PIX_IDX, 5);
    check_eq("s5.pre_data", sif.PIX_DATA, 10'h001);
    check_eq("s5.pre_busy", sif.BUSY, 1);
    FPGA_RST = 1'b0;
    #1;
    check_all_zero("s5.rst");
    repeat (3) @(negedge FPGA_CLK);
    check_all_zero("s5.rst_hold");
    FPGA_RST = 1'b1;
    check_eq("s5.no_eoc", eoc_rise_n - b_eoc, 0);
    run_cycle(6, t0, tbase);
    check_cycle("s5", t0, tbase, 6);

    // 6: five back-to-back cycles counted on EOC rising edges
    b_eoc = eoc_rise_n;
    for (int c = 0; c < 5; c++) run_cycle(4 + c, t0, tbase);
    check_eq("s6.eoc_edges", eoc_rise_n - b_eoc, 5);
    check_eq("s6.integ_len", sif.INTEG_LEN, 8);
    check_eq("s6.busy", sif.BUSY, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
